// File: rtl/lector_ram_audio.sv
// Audio sample reader: on each audio frame edge, fetches one 16-bit sample from
// external RAM, walking the song of the selected level and wrapping at its end.
module lector_ram_audio #(
   parameter int unsigned LATENCIA  = 3,
   parameter logic [25:0] INICIO_N1 = 26'h0000000,
   parameter logic [25:0] INICIO_N2 = 26'h0100000,
   parameter logic [25:0] INICIO_N3 = 26'h0200000,
   parameter logic [25:0] LONGITUD  = 26'h00FFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        habilitador,
   input  logic        pausa,
   input  logic        nivel2,
   input  logic        nivel3,
   input  logic [15:0] DataRAM,
   output logic [25:0] DireccionRAM,
   output logic        ram_ce_n,
   output logic        ram_oe_n,
   output logic        ram_we_n,
   output logic [15:0] muestra,
   output logic        muestra_valida,
   output logic        fin_cancion,
   output logic        sobrecarga
);

   localparam logic [1:0] ESPERA  = 2'd0;
   localparam logic [1:0] LEYENDO = 2'd1;
   localparam logic [1:0] ENTREGA = 2'd2;

   localparam logic [3:0] CntIni = 4'(LATENCIA - 1);

   function automatic logic [1:0] nivel_sel(input logic n2, input logic n3);
      if (n3) begin
         nivel_sel = 2'd2;
      end else if (n2) begin
         nivel_sel = 2'd1;
      end else begin
         nivel_sel = 2'd0;
      end
   endfunction

   function automatic logic [25:0] inicio_de(input logic [1:0] nivel);
      case (nivel)
         2'd1:    inicio_de = INICIO_N2;
         2'd2:    inicio_de = INICIO_N3;
         default: inicio_de = INICIO_N1;
      endcase
   endfunction

   logic [2:0]  sync_q;
   logic [1:0]  estado_q, estado_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [25:0] base_q, base_d;
   logic [25:0] indice_q, indice_d;
   logic [1:0]  nivel_q;
   logic [1:0]  nivel_act_q, nivel_act_d;
   logic [15:0] muestra_q, muestra_d;
   logic        sobrecarga_q, sobrecarga_d;

   logic        flanco;
   logic        nivel_cambio;
   logic        ultimo;

   // Stage 2 high with stage 3 low marks the frame edge.
   assign flanco       = sync_q[1] & ~sync_q[2];
   assign nivel_cambio = (nivel_q != nivel_act_q);
   assign ultimo       = (indice_q == LONGITUD);

   always_comb begin
      estado_d     = estado_q;
      cnt_d        = cnt_q;
      base_d       = base_q;
      indice_d     = indice_q;
      nivel_act_d  = nivel_act_q;
      muestra_d    = muestra_q;
      sobrecarga_d = sobrecarga_q;
      case (estado_q)
         ESPERA: begin
            if (nivel_cambio) begin
               base_d      = inicio_de(nivel_q);
               indice_d    = '0;
               nivel_act_d = nivel_q;
            end
            if (flanco && !pausa) begin
               estado_d = LEYENDO;
               cnt_d    = CntIni;
            end
         end
         LEYENDO: begin
            if (flanco) begin
               sobrecarga_d = 1'b1;
            end
            if (cnt_q == 4'd0) begin
               muestra_d = DataRAM;
               estado_d  = ENTREGA;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ENTREGA: begin
            if (flanco) begin
               sobrecarga_d = 1'b1;
            end
            estado_d = ESPERA;
            // A pending level change overrides both increment and wrap.
            if (nivel_cambio) begin
               base_d      = inicio_de(nivel_q);
               indice_d    = '0;
               nivel_act_d = nivel_q;
            end else if (ultimo) begin
               indice_d = '0;
            end else begin
               indice_d = indice_q + 26'd1;
            end
         end
         default: begin
            estado_d = ESPERA;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q       <= 3'b000;
         estado_q     <= ESPERA;
         cnt_q        <= 4'd0;
         base_q       <= inicio_de(nivel_sel(nivel2, nivel3));
         indice_q     <= '0;
         nivel_q      <= nivel_sel(nivel2, nivel3);
         nivel_act_q  <= nivel_sel(nivel2, nivel3);
         muestra_q    <= 16'h0000;
         sobrecarga_q <= 1'b0;
      end else begin
         sync_q       <= {sync_q[1:0], habilitador};
         estado_q     <= estado_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         indice_q     <= indice_d;
         nivel_q      <= nivel_sel(nivel2, nivel3);
         nivel_act_q  <= nivel_act_d;
         muestra_q    <= muestra_d;
         sobrecarga_q <= sobrecarga_d;
      end
   end

   assign DireccionRAM   = base_q + indice_q;
   assign ram_ce_n       = (estado_q != LEYENDO);
   assign ram_oe_n       = (estado_q != LEYENDO);
   assign ram_we_n       = 1'b1;
   assign muestra        = muestra_q;
   assign muestra_valida = (estado_q == ENTREGA);
   assign fin_cancion    = (estado_q == ENTREGA) && ultimo;
   assign sobrecarga     = sobrecarga_q;

endmodule

// File: tb/tb_lector_ram_audio.sv
// Bench for lector_ram_audio: table of reads plus overload, pause and reset sequences.
module tb_lector_ram_audio;

   localparam int unsigned LAT = 3;

   logic        clk;
   logic        reset;
   logic        habilitador;
   logic        pausa;
   logic        nivel2;
   logic        nivel3;
   logic [15:0] DataRAM;
   logic [25:0] DireccionRAM;
   logic        ram_ce_n;
   logic        ram_oe_n;
   logic        ram_we_n;
   logic [15:0] muestra;
   logic        muestra_valida;
   logic        fin_cancion;
   logic        sobrecarga;

   lector_ram_audio #(
      .LATENCIA  (LAT),
      .INICIO_N1 (26'h0000000),
      .INICIO_N2 (26'h0100000),
      .INICIO_N3 (26'h0200000),
      .LONGITUD  (26'h0000003)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .habilitador    (habilitador),
      .pausa          (pausa),
      .nivel2         (nivel2),
      .nivel3         (nivel3),
      .DataRAM        (DataRAM),
      .DireccionRAM   (DireccionRAM),
      .ram_ce_n       (ram_ce_n),
      .ram_oe_n       (ram_oe_n),
      .ram_we_n       (ram_we_n),
      .muestra        (muestra),
      .muestra_valida (muestra_valida),
      .fin_cancion    (fin_cancion),
      .sobrecarga     (sobrecarga)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        n2;
      logic        n3;
      logic [15:0] data;
      logic [25:0] addr;
      logic        wrap;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic [25:0] addr;
      logic        wrap;
   } exp_t;

   exp_t        sb[$];
   vec_t        vecs[9];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          ce_run   = 0;
   int          ce_total = 0;
   int          n_valid  = 0;
   logic        prev_valid = 1'b0;
   logic [25:0] lead_addr  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Samples the DUT on each falling edge and retires scoreboard entries on muestra_valida.
   task automatic run_cycles(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("oe_eq_ce", {31'd0, ram_oe_n}, {31'd0, ram_ce_n});
         check("we_high", {31'd0, ram_we_n}, 32'd1);
         if (!ram_ce_n) begin
            if (ce_run == 0) begin
               lead_addr = DireccionRAM;
            end else begin
               check("addr_stable", {6'd0, DireccionRAM}, {6'd0, lead_addr});
            end
            ce_run++;
            ce_total++;
         end
         check("valid_pulse", {31'd0, muestra_valida & prev_valid}, 32'd0);
         prev_valid = muestra_valida;
         if (muestra_valida) begin
            n_valid++;
            check("valid_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("muestra", {16'd0, muestra}, {16'd0, e.data});
               check("read_addr", {6'd0, lead_addr}, {6'd0, e.addr});
               check("fin_cancion", {31'd0, fin_cancion}, {31'd0, e.wrap});
               check("ce_cycles", ce_run, LAT);
            end
            ce_run = 0;
         end else begin
            check("fin_idle", {31'd0, fin_cancion}, 32'd0);
         end
      end
   endtask

   task automatic do_read(input vec_t v);
      exp_t e;
      nivel2 = v.n2;
      nivel3 = v.n3;
      run_cycles(3);
      DataRAM = v.data;
      e.data = v.data;
      e.addr = v.addr;
      e.wrap = v.wrap;
      sb.push_back(e);
      habilitador = 1'b1;
      run_cycles(12);
      habilitador = 1'b0;
      run_cycles(4);
      check("sb_drained", sb.size(), 0);
      sb.delete();
      check("muestra_held", {16'd0, muestra}, {16'd0, v.data});
   endtask

   initial begin
      logic [15:0] m_snap;
      logic [25:0] a_snap;
      int          ce_snap;
      int          v_snap;
      exp_t        e;

      vecs[0] = '{1'b0, 1'b0, 16'hA55A, 26'h0000000, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 16'h1234, 26'h0000001, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 16'hBEEF, 26'h0000002, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 16'h0F0F, 26'h0000003, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 16'h7777, 26'h0000000, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 16'hCAFE, 26'h0200000, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 16'h0001, 26'h0200001, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 16'h8000, 26'h0100000, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 16'hFFFF, 26'h0100001, 1'b0};

      reset       = 1'b0;
      habilitador = 1'b0;
      pausa       = 1'b0;
      nivel2      = 1'b0;
      nivel3      = 1'b0;
      DataRAM     = 16'h0000;
      repeat (3) @(negedge clk);
      check("rst_ce", {31'd0, ram_ce_n}, 32'd1);
      check("rst_oe", {31'd0, ram_oe_n}, 32'd1);
      check("rst_we", {31'd0, ram_we_n}, 32'd1);
      check("rst_muestra", {16'd0, muestra}, 32'd0);
      check("rst_valid", {31'd0, muestra_valida}, 32'd0);
      check("rst_fin", {31'd0, fin_cancion}, 32'd0);
      check("rst_sobrecarga", {31'd0, sobrecarga}, 32'd0);
      check("rst_addr", {6'd0, DireccionRAM}, 32'd0);
      reset = 1'b1;
      run_cycles(3);

      for (int i = 0; i < 9; i++) begin
         do_read(vecs[i]);
      end
      check("no_overload_yet", {31'd0, sobrecarga}, 32'd0);

      // Pause raised mid-read must not abort it.
      DataRAM = 16'h1111;
      e = '{16'h1111, 26'h0100002, 1'b0};
      sb.push_back(e);
      habilitador = 1'b1;
      run_cycles(3);
      pausa = 1'b1;
      run_cycles(9);
      habilitador = 1'b0;
      run_cycles(4);
      check("pause_midread_done", sb.size(), 0);
      sb.delete();

      // Paused: frame edges are ignored entirely.
      m_snap  = muestra;
      a_snap  = DireccionRAM;
      ce_snap = ce_total;
      v_snap  = n_valid;
      for (int i = 0; i < 5; i++) begin
         habilitador = 1'b1;
         run_cycles(4);
         habilitador = 1'b0;
         run_cycles(4);
      end
      check("pause_no_ce", ce_total, ce_snap);
      check("pause_no_valid", n_valid, v_snap);
      check("pause_muestra", {16'd0, muestra}, {16'd0, m_snap});
      check("pause_addr", {6'd0, DireccionRAM}, 32'h0100003);
      check("pause_addr_same", {6'd0, DireccionRAM}, {6'd0, a_snap});
      check("pause_sobrecarga", {31'd0, sobrecarga}, 32'd0);
      pausa = 1'b0;
      run_cycles(2);

      // Second frame edge while the first read is in flight.
      DataRAM = 16'h2222;
      e = '{16'h2222, 26'h0100003, 1'b1};
      sb.push_back(e);
      v_snap = n_valid;
      habilitador = 1'b1;
      run_cycles(1);
      habilitador = 1'b0;
      run_cycles(1);
      habilitador = 1'b1;
      run_cycles(12);
      habilitador = 1'b0;
      run_cycles(6);
      check("overload_one_valid", n_valid - v_snap, 1);
      check("overload_drained", sb.size(), 0);
      sb.delete();
      check("sobrecarga_set", {31'd0, sobrecarga}, 32'd1);
      do_read('{1'b1, 1'b0, 16'h3333, 26'h0100000, 1'b0});
      check("sobrecarga_sticky", {31'd0, sobrecarga}, 32'd1);

      // Reset on the second read cycle; level select drops to level 1 at the same time.
      DataRAM = 16'h4444;
      v_snap = n_valid;
      habilitador = 1'b1;
      run_cycles(4);
      check("midrst_reading", {31'd0, ram_ce_n}, 32'd0);
      reset       = 1'b0;
      nivel2      = 1'b0;
      habilitador = 1'b0;
      run_cycles(1);
      ce_run = 0;
      check("midrst_ce", {31'd0, ram_ce_n}, 32'd1);
      check("midrst_oe", {31'd0, ram_oe_n}, 32'd1);
      check("midrst_muestra", {16'd0, muestra}, 32'd0);
      check("midrst_sobrecarga", {31'd0, sobrecarga}, 32'd0);
      check("midrst_addr", {6'd0, DireccionRAM}, 32'd0);
      run_cycles(2);
      reset = 1'b1;
      run_cycles(4);
      check("midrst_no_valid", n_valid, v_snap);
      do_read('{1'b0, 1'b0, 16'h5555, 26'h0000000, 1'b0});
      do_read('{1'b0, 1'b0, 16'h6666, 26'h0000001, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
